// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// state codes, ALU operation codes and datapath mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam int         NUM_R_FUNCTS = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ASB_REGB    = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Table of R-type functs the datapath implements, indexed 0..NUM_R_FUNCTS-1.
  function automatic logic [5:0] r_funct(input int idx);
    case (idx)
      0:       return FN_ADD;
      1:       return FN_SUB;
      2:       return FN_AND;
      3:       return FN_OR;
      default: return FN_SLT;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// Combinational ALU decoder: maps opcode/funct to an ALU operation and flags
// whether an R-type funct is one the datapath supports.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       valid
);

  logic [NUM_R_FUNCTS-1:0] funct_hit;

  generate
    for (genvar gi = 0; gi < NUM_R_FUNCTS; gi++) begin : g_funct
      assign funct_hit[gi] = (funct == r_funct(gi));
    end
  endgenerate

  always_comb begin
    alu_code = ALU_ADD;
    valid    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        valid = |funct_hit;
        case (funct)
          FN_SUB:  alu_code = ALU_SUB;
          FN_AND:  alu_code = ALU_AND;
          FN_OR:   alu_code = ALU_OR;
          FN_SLT:  alu_code = ALU_SLT;
          default: alu_code = ALU_ADD;
        endcase
      end
      OP_ANDI: alu_code = ALU_AND;
      OP_ORI:  alu_code = ALU_OR;
      default: alu_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared ALU and memory port.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic [1:0]        pc_src,
  output logic              ext_sel,
  output logic              illegal,
  output logic [STATE_W-1:0] state_o
);

  state_t     state_reg, state_next;
  logic [3:0] dec_alu, alu_code;
  logic       dec_valid, imm_signed;
  logic       pc_en_raw, ir_write_raw, reg_write_raw;
  logic       mem_read_raw, mem_write_raw, illegal_raw;

  alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_code (dec_alu),
    .valid    (dec_valid)
  );

  assign imm_signed = (opcode != OP_ANDI) && (opcode != OP_ORI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    pc_en_raw     = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_REGB;
    alu_code      = ALU_ADD;
    pc_src        = PCS_ALU;
    ext_sel       = 1'b1;
    case (state_reg)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = ASB_FOUR;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ASB_IMM_SH2;
        case (opcode)
          OP_RTYPE:                 state_next = dec_valid ? S_R_EXEC : S_TRAP;
          OP_LW, OP_SW:             state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_I_EXEC;
          OP_J:                     state_next = S_JUMP;
          default:                  state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        if (opcode == OP_LW)      state_next = S_MEM_READ;
        else if (opcode == OP_SW) state_next = S_MEM_WRITE;
        else                      state_next = S_TRAP;
      end
      S_MEM_READ: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        state_next    = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_code   = dec_alu;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        // opcode[0] separates bne (1) from beq (0)
        alu_src_a  = 1'b1;
        alu_code   = ALU_SUB;
        pc_src     = PCS_ALUOUT;
        pc_en_raw  = zero ^ opcode[0];
        state_next = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ASB_IMM;
        alu_code   = dec_alu;
        ext_sel    = imm_signed;
        state_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write_raw = 1'b1;
        alu_code      = dec_alu;
        ext_sel       = imm_signed;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_en_raw  = 1'b1;
        pc_src     = PCS_JUMP;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal_raw = 1'b1;
      end
      default: state_next = S_TRAP;
    endcase
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign pc_en     = pc_en_raw     & rst_n;
  assign ir_write  = ir_write_raw  & rst_n;
  assign reg_write = reg_write_raw & rst_n;
  assign mem_read  = mem_read_raw  & rst_n;
  assign mem_write = mem_write_raw & rst_n;
  assign illegal   = illegal_raw   & rst_n;
  assign alu_ctrl  = ALUC_W'(alu_code);
  assign state_o   = STATE_W'(state_reg);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes hand-computed expected
// output vectors, a monitor pops and compares one per clock.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, ext_sel, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_ctrl, state_o;

  logic [22:0] exp_q[$];
  string       name_q[$];
  bit          done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mc_ctrl_fsm #(.STATE_W(4), .ALUC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .ext_sel(ext_sel), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Field order: st, pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
  // mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, ext_sel, illegal
  function automatic logic [22:0] mk(input logic [3:0] st, input logic pe, io, mrd, mwr,
                                     irw, rd, m2r, rw, asa, input logic [1:0] asb,
                                     input logic [3:0] ac, input logic [1:0] ps,
                                     input logic ext, ill);
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, asa, asb, ac, ps, ext, ill, st};
  endfunction

  task automatic cyc(input string nm, input logic r, input logic [5:0] op, fn,
                     input logic z, mr, input logic [22:0] e);
    @(posedge clk);
    #1;
    rst_n = r; opcode = op; funct = fn; zero = z; mem_ready = mr;
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  initial begin : stimulus
    logic [22:0] rstv, f_go, f_wait, dec, trapv;
    rstv   = mk(4'd0, 0,0,0,0,0, 0,0,0, 0,2'b01,4'b0010,2'b00,1,0);
    f_go   = mk(4'd0, 1,0,1,0,1, 0,0,0, 0,2'b01,4'b0010,2'b00,1,0);
    f_wait = mk(4'd0, 0,0,1,0,0, 0,0,0, 0,2'b01,4'b0010,2'b00,1,0);
    dec    = mk(4'd1, 0,0,0,0,0, 0,0,0, 0,2'b11,4'b0010,2'b00,1,0);
    trapv  = mk(4'd12, 0,0,0,0,0, 0,0,0, 0,2'b00,4'b0010,2'b00,1,1);

    cyc("reset_hold", 0, 6'b001101, 6'd0, 0, 1, rstv);
    // ori
    cyc("ori_fetch", 1, 6'b001101, 6'd0, 0, 1, f_go);
    cyc("ori_dec",   1, 6'b001101, 6'd0, 0, 1, dec);
    cyc("ori_iexec", 1, 6'b001101, 6'd0, 0, 1, mk(4'd9, 0,0,0,0,0, 0,0,0, 1,2'b10,4'b0001,2'b00,0,0));
    cyc("ori_iwb",   1, 6'b001101, 6'd0, 0, 1, mk(4'd10, 0,0,0,0,0, 0,0,1, 0,2'b00,4'b0001,2'b00,0,0));
    // lw with two wait states in MEM_READ
    cyc("lw_fetch",  1, 6'b100011, 6'd0, 0, 1, f_go);
    cyc("lw_dec",    1, 6'b100011, 6'd0, 0, 1, dec);
    cyc("lw_addr",   1, 6'b100011, 6'd0, 0, 0, mk(4'd2, 0,0,0,0,0, 0,0,0, 1,2'b10,4'b0010,2'b00,1,0));
    cyc("lw_rd_w0",  1, 6'b100011, 6'd0, 0, 0, mk(4'd3, 0,1,1,0,0, 0,0,0, 0,2'b00,4'b0010,2'b00,1,0));
    cyc("lw_rd_w1",  1, 6'b100011, 6'd0, 0, 0, mk(4'd3, 0,1,1,0,0, 0,0,0, 0,2'b00,4'b0010,2'b00,1,0));
    cyc("lw_rd_ok",  1, 6'b100011, 6'd0, 0, 1, mk(4'd3, 0,1,1,0,0, 0,0,0, 0,2'b00,4'b0010,2'b00,1,0));
    cyc("lw_wb",     1, 6'b100011, 6'd0, 0, 1, mk(4'd4, 0,0,0,0,0, 0,1,1, 0,2'b00,4'b0010,2'b00,1,0));
    // bne taken / not taken, beq taken
    cyc("bne_fetch", 1, 6'b000101, 6'd0, 1, 1, f_go);
    cyc("bne_dec",   1, 6'b000101, 6'd0, 1, 1, dec);
    cyc("bne_z1",    1, 6'b000101, 6'd0, 1, 1, mk(4'd8, 0,0,0,0,0, 0,0,0, 1,2'b00,4'b0110,2'b01,1,0));
    cyc("bne_fetch", 1, 6'b000101, 6'd0, 0, 1, f_go);
    cyc("bne_dec",   1, 6'b000101, 6'd0, 0, 1, dec);
    cyc("bne_z0",    1, 6'b000101, 6'd0, 0, 1, mk(4'd8, 1,0,0,0,0, 0,0,0, 1,2'b00,4'b0110,2'b01,1,0));
    cyc("beq_fetch", 1, 6'b000100, 6'd0, 1, 1, f_go);
    cyc("beq_dec",   1, 6'b000100, 6'd0, 1, 1, dec);
    cyc("beq_z1",    1, 6'b000100, 6'd0, 1, 1, mk(4'd8, 1,0,0,0,0, 0,0,0, 1,2'b00,4'b0110,2'b01,1,0));
    // addi (with one fetch wait) then j
    cyc("addi_fwait", 1, 6'b001000, 6'd0, 0, 0, f_wait);
    cyc("addi_fetch", 1, 6'b001000, 6'd0, 0, 1, f_go);
    cyc("addi_dec",   1, 6'b001000, 6'd0, 0, 1, dec);
    cyc("addi_iexec", 1, 6'b001000, 6'd0, 0, 1, mk(4'd9, 0,0,0,0,0, 0,0,0, 1,2'b10,4'b0010,2'b00,1,0));
    cyc("addi_iwb",   1, 6'b000010, 6'd0, 0, 1, mk(4'd10, 0,0,0,0,0, 0,0,1, 0,2'b00,4'b0010,2'b00,1,0));
    cyc("j_fetch",    1, 6'b000010, 6'd0, 0, 1, f_go);
    cyc("j_dec",      1, 6'b000010, 6'd0, 0, 1, dec);
    cyc("j_jump",     1, 6'b000010, 6'd0, 0, 1, mk(4'd11, 1,0,0,0,0, 0,0,0, 0,2'b00,4'b0010,2'b10,1,0));
    // R-type sub
    cyc("sub_fetch",  1, 6'b000000, 6'b100010, 0, 1, f_go);
    cyc("sub_dec",    1, 6'b000000, 6'b100010, 0, 1, dec);
    cyc("sub_rexec",  1, 6'b000000, 6'b100010, 0, 1, mk(4'd6, 0,0,0,0,0, 0,0,0, 1,2'b00,4'b0110,2'b00,1,0));
    cyc("sub_alu_wb", 1, 6'b000000, 6'b100010, 0, 1, mk(4'd7, 0,0,0,0,0, 1,0,1, 0,2'b00,4'b0010,2'b00,1,0));
    // sw, reset asserted mid MEM_WRITE wait
    cyc("sw_fetch",  1, 6'b101011, 6'd0, 0, 1, f_go);
    cyc("sw_dec",    1, 6'b101011, 6'd0, 0, 1, dec);
    cyc("sw_addr",   1, 6'b101011, 6'd0, 0, 0, mk(4'd2, 0,0,0,0,0, 0,0,0, 1,2'b10,4'b0010,2'b00,1,0));
    cyc("sw_wr_w0",  1, 6'b101011, 6'd0, 0, 0, mk(4'd5, 0,1,0,1,0, 0,0,0, 0,2'b00,4'b0010,2'b00,1,0));
    cyc("sw_wr_w1",  1, 6'b101011, 6'd0, 0, 0, mk(4'd5, 0,1,0,1,0, 0,0,0, 0,2'b00,4'b0010,2'b00,1,0));
    cyc("sw_rst",    0, 6'b101011, 6'd0, 0, 1, rstv);
    cyc("rel_fetch", 1, 6'b000000, 6'b000111, 0, 1, f_go);
    // illegal funct traps and stays
    cyc("bad_dec",   1, 6'b000000, 6'b000111, 0, 1, dec);
    for (int i = 0; i < 10; i++) begin
      logic [5:0] op_v, fn_v;
      logic [3:0] iv;
      op_v = 6'((i * 7) % 64);
      fn_v = 6'((i * 13) % 64);
      iv = 4'(i);
      cyc("trap_hold", 1, op_v, fn_v, iv[0], iv[1], trapv);
    end
    cyc("trap_rst",  0, 6'd0, 6'd0, 0, 0, rstv);
    done = 1'b1;
  end

  initial begin : monitor
    logic [22:0] act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, ext_sel, illegal, state_o};
        checks++;
        if ((pc_en & reg_write) !== 1'b0) begin
          errors++;
          $display("FAIL %s pc_en and reg_write both high (state %0d)", nm, state_o);
        end
        if (act !== e) begin
          errors++;
          $display("FAIL %s got %h want %h (state %0d)", nm, act, e, state_o);
        end else begin
          $display("ok %s state=%0d vec=%h", nm, state_o, act);
        end
      end else if (done) begin
        break;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("PASS");
    else             $display("FAIL %0d errors", errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback through one shared ALU and memory port.
- Drives every mux select and write enable, including ext_sel, which configures the immediate extender for zero- or sign-extension.
- Sits beside the datapath top and takes the instruction register's opcode/funct fields plus the ALU zero flag.

Parameters:
- STATE_W, 4, state register width.
- ALUC_W, 4, ALU control code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU zero flag, combinational from the current cycle.
- mem_ready  in  1  memory handshake; access completes on a cycle with mem_ready=1.
- pc_en  out  1  PC load enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B: 00=regB, 01=4, 10=ext imm, 11=ext imm<<2.
- alu_ctrl  out  ALUC_W  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- ext_sel  out  1  immediate extender mode: 0=zero-extend, 1=sign-extend.
- illegal  out  1  trap indicator.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Moore FSM. State register is asynchronously reset to FETCH on rst_n low.
- While rst_n=0: pc_en, ir_write, reg_write, mem_read, mem_write and illegal are all forced to 0; the other outputs take their FETCH values.
- Deassertion is synchronous to the next clk edge.
- Defaults in every state: all strobes 0, selects 0, alu_ctrl=ADD, ext_sel=1.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, ALU_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11, TRAP=12. Codes 13-15 go to TRAP.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD.
  - ir_write=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target precompute). Next state by opcode:
  - 000000 R-type → R_EXEC if funct is one of 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct → TRAP.
  - 100011 lw, 101011 sw → MEM_ADDR.
  - 000100 beq, 000101 bne → BRANCH.
  - 001000 addi, 001100 andi, 001101 ori → I_EXEC.
  - 000010 j → JUMP.
  - Any other opcode → TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD, ext_sel=1. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Waits on mem_ready, then → MEM_WB.
- MEM_WRITE: mem_write=1, iord=1. Waits on mem_ready, then → FETCH.
  - The strobe stays asserted throughout the wait.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct → ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01 → FETCH.
  - pc_en = zero for beq, ~zero for bne.
  - The opcode bit is sampled combinationally; the instruction register is stable here.
- I_EXEC: alu_src_a=1, alu_src_b=10 → I_WB.
  - addi: ADD, ext_sel=1.
  - andi: AND, ext_sel=0.
  - ori: OR, ext_sel=0.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - ext_sel/alu_ctrl hold the I_EXEC values for that opcode.
- JUMP: pc_en=1, pc_src=10 → FETCH.
- TRAP: illegal=1, all strobes 0. Absorbing; only reset exits.
- Latencies with zero memory wait states:
  - R-type, addi/andi/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne, j: 3 cycles.
  - Each mem_ready=0 cycle adds 1.
- Reset mid-instruction: the instruction is abandoned and no further write strobes occur. After release, the first edge is in FETCH.
- pc_en is never asserted together with reg_write in the same cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - ALU control codes;
  - alu_src_b and pc_src select codes.
- Sub-module alu_dec: combinational funct/opcode → alu_ctrl plus a valid flag. mc_ctrl_fsm uses the valid flag for the TRAP decision.

Test Plan:
- Reset asserted while in MEM_WRITE → mem_write drops to 0 immediately, state_o=0. After release and mem_ready=1: FETCH asserts ir_write=1 and pc_en=1.
- ori (opcode 001101), mem_ready=1 throughout → states 0,1,9,10,0. In states 9 and 10: ext_sel=0, alu_ctrl=0001. reg_write=1 only in state 10.
- lw with mem_ready low for 2 cycles in MEM_READ → state 3 held 3 cycles with mem_read=1 and iord=1. Then MEM_WB: reg_write=1, mem_to_reg=1.
- bne with zero=1 → pc_en=0 in BRANCH. Same test with zero=0 → pc_en=1, pc_src=01.
- R-type with funct 000111 → DECODE then TRAP (state 12), illegal=1. Stays there for 10 cycles regardless of inputs.
- addi then j back-to-back → addi takes 4 cycles with ext_sel=1, alu_ctrl=0010. j takes 3 cycles with pc_src=10 and pc_en=1 in state 11.
